// File: rtl/exe_muldiv_unit_if.sv
// Request/response bundle between the EXE-stage issue logic and the iterative
// mul/div unit. The master drives the request side and observes HI/LO/Busy/Done.
interface exe_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start_IN;
    logic [2:0]       Op_IN;
    logic [WIDTH-1:0] OperandA_IN;
    logic [WIDTH-1:0] OperandB_IN;
    logic             Flush_IN;
    logic             Busy_OUT;
    logic             Done_OUT;
    logic [WIDTH-1:0] HI_OUT;
    logic [WIDTH-1:0] LO_OUT;

    modport master (
        output Start_IN, Op_IN, OperandA_IN, OperandB_IN, Flush_IN,
        input  Busy_OUT, Done_OUT, HI_OUT, LO_OUT
    );

    modport slave (
        input  Start_IN, Op_IN, OperandA_IN, OperandB_IN, Flush_IN,
        output Busy_OUT, Done_OUT, HI_OUT, LO_OUT
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle,
// followed by a FIX cycle that applies signs and writes HI/LO.
// Optional build macro MULDIV_MADD_EN: ops 110/111 accumulate the product into
// {HI,LO}; without it they behave as MULT/MULTU.
module exe_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               CLOCK,
    input logic               RESET,
    exe_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // Context latched at acceptance; lives for the whole operation.
    typedef struct packed {
        logic             isDiv;
        logic             negLo;    // negate product (mul) or quotient (div)
        logic             negHi;    // negate remainder (div)
        logic             divZero;
`ifdef MULDIV_MADD_EN
        logic             isMadd;
`endif
        logic [WIDTH-1:0] srcA;     // raw dividend, returned on divide by zero
        logic [WIDTH-1:0] src;      // multiplicand (mul) or divisor (div) magnitude
    } ctx_t;

    state_t               state, nextState;
    ctx_t                 ctx;
    logic [2*WIDTH-1:0]   work;     // mul: {partial, multiplier}; div: {rem, quo}
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     hiReg, loReg;
    logic                 doneReg;

    logic                 accept, isDivIn, isMtIn, signedIn, sA, sB;
    logic [WIDTH-1:0]     magA, magB;
    logic [2*WIDTH-1:0]   iterNext;
    logic [WIDTH-1:0]     fixHi, fixLo;

    // Decode of the incoming request and operand magnitudes.
    always_comb begin
        accept   = (state == IDLE) && bus.Start_IN && !bus.Flush_IN;
        isDivIn  = (bus.Op_IN[2:1] == 2'b01);
        isMtIn   = (bus.Op_IN[2:1] == 2'b10);
        signedIn = !bus.Op_IN[0];
        sA       = signedIn && bus.OperandA_IN[WIDTH-1];
        sB       = signedIn && bus.OperandB_IN[WIDTH-1];
        magA     = sA ? -bus.OperandA_IN : bus.OperandA_IN;
        magB     = sB ? -bus.OperandB_IN : bus.OperandB_IN;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        logic [WIDTH:0] mulSum, shifted, diff;
        mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, ctx.src} : '0);
        shifted  = work[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, ctx.src};
        iterNext = '0;
        if (ctx.isDiv)
            iterNext = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                        work[WIDTH-2:0], !diff[WIDTH]};
        else
            iterNext = {mulSum, work[WIDTH-1:1]};
    end

    // Sign correction and (optional) accumulate for the FIX write.
    always_comb begin
        logic [2*WIDTH-1:0] prod;
        prod = ctx.negLo ? -work : work;
`ifdef MULDIV_MADD_EN
        if (ctx.isMadd)
            prod = prod + {hiReg, loReg};
`endif
        fixHi = prod[2*WIDTH-1:WIDTH];
        fixLo = prod[WIDTH-1:0];
        if (ctx.isDiv) begin
            if (ctx.divZero) begin
                fixHi = ctx.srcA;
                fixLo = '1;
            end else begin
                fixHi = ctx.negHi ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
                fixLo = ctx.negLo ? -work[WIDTH-1:0] : work[WIDTH-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= nextState;
    end

    // FSM next-state: flush squashes RUN/FIX, counter 1->0 enters FIX.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept && !isMtIn) nextState = RUN;
            RUN:     if (bus.Flush_IN) nextState = IDLE;
                     else if (cnt == CNT_W'(1)) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: busy covers the whole RUN/FIX window.
    always_comb begin
        bus.Busy_OUT = (state != IDLE);
        bus.Done_OUT = doneReg;
        bus.HI_OUT   = hiReg;
        bus.LO_OUT   = loReg;
    end

    // Datapath: operand latch, iteration, HI/LO write-back and done pulse.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            hiReg   <= '0;
            loReg   <= '0;
            work    <= '0;
            cnt     <= '0;
            ctx     <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (isMtIn) begin
                        if (bus.Op_IN[0]) loReg <= bus.OperandA_IN;
                        else              hiReg <= bus.OperandA_IN;
                    end else begin
                        ctx.isDiv   <= isDivIn;
                        ctx.negLo   <= sA ^ sB;
                        ctx.negHi   <= sA;
                        ctx.divZero <= isDivIn && (bus.OperandB_IN == '0);
`ifdef MULDIV_MADD_EN
                        ctx.isMadd  <= (bus.Op_IN[2:1] == 2'b11);
`endif
                        ctx.srcA    <= bus.OperandA_IN;
                        ctx.src     <= isDivIn ? magB : magA;
                        work        <= {{WIDTH{1'b0}}, (isDivIn ? magA : magB)};
                        cnt         <= CNT_W'(WIDTH);
                    end
                end
                RUN: if (!bus.Flush_IN) begin
                    work <= iterNext;
                    cnt  <= cnt - CNT_W'(1);
                end
                FIX: if (!bus.Flush_IN) begin
                    hiReg   <= fixHi;
                    loReg   <= fixLo;
                    doneReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: expected HI/LO pushed on issue,
// popped and compared on Done_OUT.
module tb_exe_muldiv_unit;
    localparam int W = 32;

    logic CLOCK = 1'b0;
    logic RESET;
    always #5 CLOCK = ~CLOCK;

    exe_muldiv_unit_if #(.WIDTH(W)) bus ();
    exe_muldiv_unit #(.WIDTH(W)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] expQ[$];
    logic [W-1:0]   mHi = '0, mLo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        int ia, ib;
        if (op[1:0] == 2'b10 && op[2] == 1'b0 || op == 3'b011) begin
            if (b == '0) return {a, 32'hFFFFFFFF};
            if (op[0]) return {a % b, a / b};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            ia = a; ib = b;
            return {32'(ia % ib), 32'(ia / ib)};
        end
        if (op[0]) p = {32'h0, a} * {32'h0, b};
        else begin
            sa = $signed(a); sb = $signed(b);
            p = sa * sb;
        end
`ifdef MULDIV_MADD_EN
        if (op[2]) p = p + {mHi, mLo};
`endif
        return p;
    endfunction

    // Drive a request for one cycle; mul/div expectations go on the queue.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        bus.Start_IN = 1'b1; bus.Op_IN = op; bus.OperandA_IN = a; bus.OperandB_IN = b;
        if (op == 3'b100) mHi = a;
        else if (op == 3'b101) mLo = a;
        else if (push) expQ.push_back(model(op, a, b));
        @(negedge CLOCK);
        bus.Start_IN = 1'b0;
    endtask

    // Wait (bounded) for Done_OUT, counting busy cycles; optionally poke a start mid-run.
    task automatic waitDone(input string tag, input bit junk);
        int busyCnt = 0;
        bit seen = 0;
        logic [2*W-1:0] exp = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.Done_OUT) seen = 1;
            else begin
                if (bus.Busy_OUT) busyCnt++;
                if (junk && i == 5) begin
                    bus.Start_IN = 1'b1; bus.Op_IN = 3'b011;
                    bus.OperandA_IN = 32'd9; bus.OperandB_IN = 32'd3;
                end else if (junk && i == 6) bus.Start_IN = 1'b0;
                @(negedge CLOCK);
            end
        end
        bus.Start_IN = 1'b0;
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_busycycles"}, busyCnt, W + 1);
        if (expQ.size() > 0) exp = expQ.pop_front();
        chk({tag, "_hi"}, bus.HI_OUT, exp[2*W-1:W]);
        chk({tag, "_lo"}, bus.LO_OUT, exp[W-1:0]);
        mHi = exp[2*W-1:W];
        mLo = exp[W-1:0];
    endtask

    initial begin
        RESET = 1'b1;
        bus.Start_IN = 0; bus.Op_IN = 0; bus.OperandA_IN = 0; bus.OperandB_IN = 0; bus.Flush_IN = 0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        chk("rst_busy", bus.Busy_OUT, 0);
        chk("rst_done", bus.Done_OUT, 0);
        chk("rst_hi", bus.HI_OUT, 0);
        chk("rst_lo", bus.LO_OUT, 0);

        // MULT -3 * 5
        issue(3'b000, 32'hFFFFFFFD, 32'd5, 1);
        waitDone("mult", 0);
        chk("mult_hi_const", bus.HI_OUT, 32'hFFFFFFFF);
        chk("mult_lo_const", bus.LO_OUT, 32'hFFFFFFF1);
        @(negedge CLOCK);
        chk("mult_done_pulse", bus.Done_OUT, 0);

        // DIVU 100/7, then DIV -7/2 issued in the Done cycle
        issue(3'b011, 32'd100, 32'd7, 1);
        waitDone("divu", 0);
        chk("divu_lo_const", bus.LO_OUT, 32'h0000000E);
        issue(3'b010, 32'hFFFFFFF9, 32'd2, 1);
        waitDone("div_b2b", 0);
        chk("div_hi_const", bus.HI_OUT, 32'hFFFFFFFF);

        // Divide by zero with an ignored start mid-run, then signed overflow
        issue(3'b010, 32'h12345678, 32'd0, 1);
        waitDone("divzero", 1);
        chk("divzero_lo_const", bus.LO_OUT, 32'hFFFFFFFF);
        @(negedge CLOCK);
        chk("ignored_start_busy", bus.Busy_OUT, 0);
        chk("ignored_start_done", bus.Done_OUT, 0);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 1);
        waitDone("divovf", 0);
        chk("divovf_lo_const", bus.LO_OUT, 32'h80000000);

        // MTHI, then a MULTU flushed mid-run
        issue(3'b100, 32'hAAAA0000, 32'd0, 0);
        chk("mthi_hi", bus.HI_OUT, 32'hAAAA0000);
        chk("mthi_busy", bus.Busy_OUT, 0);
        issue(3'b001, 32'd3, 32'd4, 0);
        repeat (8) @(negedge CLOCK);
        bus.Flush_IN = 1'b1;
        @(negedge CLOCK);
        bus.Flush_IN = 1'b0;
        chk("flush_busy", bus.Busy_OUT, 0);
        for (int i = 0; i < 4; i++) begin
            chk("flush_nodone", bus.Done_OUT, 0);
            @(negedge CLOCK);
        end
        chk("flush_hi", bus.HI_OUT, mHi);
        chk("flush_lo", bus.LO_OUT, mLo);

        // Flush in IDLE blocks an MTLO
        bus.Flush_IN = 1'b1; bus.Start_IN = 1'b1; bus.Op_IN = 3'b101; bus.OperandA_IN = 32'h5555;
        @(negedge CLOCK);
        bus.Flush_IN = 1'b0; bus.Start_IN = 1'b0;
        chk("idleflush_lo", bus.LO_OUT, mLo);
        chk("idleflush_busy", bus.Busy_OUT, 0);

        // Reset mid-run, then a normal op
        issue(3'b000, 32'd7, 32'd9, 0);
        repeat (5) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        mHi = '0; mLo = '0;
        chk("midrst_hi", bus.HI_OUT, 0);
        chk("midrst_lo", bus.LO_OUT, 0);
        chk("midrst_busy", bus.Busy_OUT, 0);
        chk("midrst_done", bus.Done_OUT, 0);
        issue(3'b000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1);
        waitDone("post_rst", 0);
        chk("post_rst_lo_const", bus.LO_OUT, 32'd4);

        // MADDU accumulate (or plain MULTU without the feature)
        issue(3'b100, 32'h0, 32'd0, 0);
        issue(3'b101, 32'hFFFFFFFF, 32'd0, 0);
        issue(3'b111, 32'd1, 32'd1, 1);
        waitDone("maddu", 0);
`ifdef MULDIV_MADD_EN
        chk("maddu_hilo_const", {bus.HI_OUT, bus.LO_OUT}, {32'd1, 32'd0});
`else
        chk("maddu_hilo_const", {bus.HI_OUT, bus.LO_OUT}, {32'd0, 32'd1});
`endif

        // A few random mul/div ops back to back
        for (int k = 0; k < 6; k++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = (k == 3) ? 32'd0 : $urandom;
            if (k[0]) b = b >> $urandom_range(0, 28);
            issue(op, a, b, 1);
            waitDone("rand", 0);
        end

        chk("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers. It succeeds the single-cycle HI/LO update path in the EXE stage.
- Sits beside the ALU in EXE. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO (and optionally MADD/MADDU) from ID/EXE, runs multi-cycle, and raises Busy_OUT so the pipeline stalls MFHI/MFLO and further mul/div ops.
- Supports flush for squashed instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- CLOCK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- Start_IN  input  1  request; sampled only when Busy_OUT=0
- Op_IN  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
- OperandA_IN  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- OperandB_IN  input  WIDTH  multiplier / divisor
- Flush_IN  input  1  cancel in-flight operation
- Busy_OUT  output  1  high in RUN and FIX states
- Done_OUT  output  1  one-cycle pulse after HI/LO are written by a mul/div
- HI_OUT  output  WIDTH  current HI register
- LO_OUT  output  WIDTH  current LO register

Behaviour:
- Reset (RESET=1 at a clock edge, any state): state=IDLE, HI=0, LO=0, Busy_OUT=0, Done_OUT=0, counter=0. A reset mid-operation discards the operation.
- States: IDLE, RUN, FIX.
- IDLE, Start_IN=1, Flush_IN=0:
  - MTHI/MTLO: HI (resp. LO) <= OperandA_IN at that edge. Stay IDLE. No Done_OUT.
  - mul/div ops: latch operand magnitudes (signed ops take the absolute value), op, and result signs. Counter <= WIDTH. Go to RUN.
- RUN: one iteration per cycle.
  - Multiply: shift-add, 1 multiplier bit per cycle.
  - Divide: restoring, 1 quotient bit per cycle.
  - Counter decrements each cycle. The edge on which the counter goes 1->0 moves to FIX.
- FIX: apply sign correction, write HI/LO, Done_OUT <= 1 for exactly the next cycle, return to IDLE.
- Latency: the acceptance edge is E0. HI/LO are updated at edge E0+WIDTH+1. Busy_OUT is high for WIDTH+1 cycles. Done_OUT is high in the cycle following that update.
- A new Start_IN is accepted in the Done_OUT cycle (back-to-back allowed).
- Start_IN while Busy_OUT=1: ignored, never queued. The stall is upstream's job.
- Multiply result: {HI,LO} = full 2*WIDTH-bit product. Signed for MULT, unsigned for MULTU.
- Divide result: LO=quotient, HI=remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- Divide by zero (DIV or DIVU): LO=all ones, HI=OperandA_IN as given. Still takes full latency with Done_OUT.
- Flush_IN=1:
  - In RUN or FIX: go to IDLE next edge. HI/LO unchanged, no Done_OUT.
  - In IDLE: Start_IN is ignored that cycle, including MTHI/MTLO.
- Flush_IN and RESET together: RESET wins.
- HI_OUT/LO_OUT are driven directly from the registers. They hold stale values while Busy_OUT=1.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: Op 110/111 perform MADD/MADDU, i.e. {HI,LO} <= {HI,LO} + product (signed/unsigned product). The addition is a 2*WIDTH-bit modulo wrap, done in FIX. Same latency as MULT.
- Not defined: Op 110/111 behave exactly as MULT/MULTU (HI/LO overwritten, no accumulate).

Test Plan (WIDTH=32):
- MULT A=0xFFFFFFFD (-3), B=5 -> Busy_OUT for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1; Done_OUT one-cycle pulse.
- DIVU A=100, B=7 -> LO=0x0000000E, HI=0x00000002. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA0000, then MULTU 3*4 started; Flush_IN asserted at cycle 10 -> Busy_OUT low next cycle, no Done_OUT, HI=0xAAAA0000 retained. Start_IN during Busy_OUT is ignored.
- RESET asserted mid-RUN of a MULT -> next cycle HI=LO=0, Busy_OUT=0, Done_OUT=0. A start in the following cycle completes normally.
- With MULDIV_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> HI=1, LO=0. Without the macro, the same sequence -> HI=0, LO=1.
